// File: rtl/fibo_request_arbiter_pkg.sv
// Shared types and default widths for the Fibonacci request arbiter and its calculator.
package fibo_arb_pkg;

  localparam int IDX_W_DEF  = 5;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/fibo_request_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first request above ptr, with wrap.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the closest one after ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = N; off >= 1; off--) begin
      idx = PTR_W'((int'(ptr) + off) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fibo_request_arbiter.sv
// Shares one Fibonacci calculator among NUM_REQ requesters, one transaction in flight.
// Optional WAIT-state watchdog is enabled by defining FIBO_ARB_TIMEOUT_EN.
module fibo_request_arbiter
  import fibo_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = IDX_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_n,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     calc_begin,
  output logic [IDX_W-1:0]         calc_n,
  input  logic [DATA_W-1:0]        calc_result,
  input  logic                     calc_done
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0] n_q;
  logic [IDX_W-1:0] n_sel;
  logic             err_q;
  logic             accept;
  logic             timed_out;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick)
  );

  always_comb begin
    pick_idx = '0;
    n_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
        n_sel    = req_n[i*IDX_W +: IDX_W];
      end
    end
  end

  assign accept = (state == IDLE) && (|pick);

`ifdef FIBO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= PTR_W'(NUM_REQ - 1);
      grant_idx <= '0;
      n_q       <= '0;
      rsp_data  <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            grant_idx <= pick_idx;
            n_q       <= n_sel;
          end
        end
        // A done on the watchdog's final cycle takes precedence over the abort.
        WAIT: begin
          if (calc_done) begin
            rsp_data <= calc_result;
            err_q    <= 1'b0;
          end else if (timed_out) begin
            rsp_data <= '0;
            err_q    <= 1'b1;
          end
        end
        RESP: ptr <= grant_idx;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (calc_done || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even before the first reset edge.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_err    = 1'b0;
    busy       = 1'b0;
    calc_begin = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        IDLE:  req_ready = pick;
        ISSUE: calc_begin = 1'b1;
        RESP: begin
          rsp_valid[grant_idx] = 1'b1;
          rsp_err              = err_q;
        end
        default: ;
      endcase
    end
  end

  assign calc_n = n_q;

endmodule

// File: tb/tb_fibo_request_arbiter.sv
// Directed bench for fibo_request_arbiter with a delayed-done calculator model.
module tb_fibo_request_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 5;
  localparam int DATA_W  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_n;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        calc_begin;
  logic [4:0]  calc_n;
  logic [15:0] calc_result;
  logic        calc_done;

  fibo_request_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .IDX_W          (IDX_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_n       (req_n),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .calc_begin  (calc_begin),
    .calc_n      (calc_n),
    .calc_result (calc_result),
    .calc_done   (calc_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [19:0] nPacked;
    int          k;
    logic [3:0]  expGrant;
    logic [4:0]  expN;
    logic [15:0] expData;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[8];

  int checkCount = 0;
  int failCount  = 0;

  int cycleNo = 0;
  int acceptCount = 0;
  int rspCount = 0;
  int overlapCount = 0;
  int acceptCycle, beginCycle, rspCycle;
  logic inFlight = 1'b0;
  logic [3:0]  lastAccept;
  logic [4:0]  beginN;
  logic [3:0]  rspVec;
  logic [15:0] rspData;
  logic        rspErrSeen;
  logic [3:0]  grantLog[$];
  logic [3:0]  rspLog[$];

  int   modelK = 0;
  int   modelCnt = 0;
  logic modelPending = 1'b0;
  logic [4:0] modelN = '0;
  logic forceDone = 1'b0;

  function automatic logic [15:0] fib(input logic [4:0] n);
    logic [15:0] a, b, t;
    a = 16'd0;
    b = 16'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One clock: observe at the falling edge, update the calculator model, return just after the rising edge.
  task automatic stepCycle();
    @(negedge clk);
    cycleNo++;
    if ((req_ready & req_valid) != 4'b0) begin
      if (inFlight) overlapCount++;
      inFlight    = 1'b1;
      lastAccept  = req_ready & req_valid;
      acceptCycle = cycleNo;
      acceptCount++;
      grantLog.push_back(lastAccept);
    end
    if (calc_begin) begin
      beginCycle = cycleNo;
      beginN     = calc_n;
    end
    if (rsp_valid != 4'b0) begin
      rspVec     = rsp_valid;
      rspData    = rsp_data;
      rspErrSeen = rsp_err;
      rspCycle   = cycleNo;
      rspCount++;
      inFlight = 1'b0;
      rspLog.push_back(rsp_valid);
    end
    calc_done = 1'b0;
    if (modelPending) begin
      modelCnt--;
      if (modelCnt == 0) begin
        calc_done    = 1'b1;
        modelPending = 1'b0;
      end
    end
    if (calc_begin) begin
      modelN       = calc_n;
      modelPending = (modelK > 0);
      modelCnt     = modelK;
    end
    if (forceDone) calc_done = 1'b1;
    calc_result = fib(modelN);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) stepCycle();
    reset        = 1'b0;
    modelPending = 1'b0;
    inFlight     = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int startAcc, startRsp, guard;
    startAcc  = acceptCount;
    startRsp  = rspCount;
    req_n     = v.nPacked;
    req_valid = v.valid;
    modelK    = v.k;
    guard = 0;
    while (acceptCount == startAcc && guard < 20) begin
      stepCycle();
      guard++;
    end
    req_valid = 4'b0;
    checkOutput({tag, ".accepted"}, acceptCount - startAcc, 1);
    guard = 0;
    while (acceptCount != startAcc && rspCount == startRsp && guard < v.expLat + 20) begin
      stepCycle();
      guard++;
    end
    checkOutput({tag, ".responded"}, rspCount - startRsp, 1);
    checkOutput({tag, ".grant"}, lastAccept, v.expGrant);
    checkOutput({tag, ".calc_n"}, beginN, v.expN);
    checkOutput({tag, ".beginLat"}, beginCycle - acceptCycle, 1);
    checkOutput({tag, ".rsp_valid"}, rspVec, v.expGrant);
    checkOutput({tag, ".rsp_data"}, rspData, v.expData);
    checkOutput({tag, ".rsp_err"}, rspErrSeen, v.expErr);
    checkOutput({tag, ".rspLat"}, rspCycle - beginCycle, v.expLat);
  endtask

  task automatic runHeld(input logic [3:0] valid, input logic [19:0] nPacked, input int nRsp,
                         input logic [3:0] expOrder[5], input string tag);
    int startRsp, startLog, guard;
    startRsp  = rspCount;
    startLog  = grantLog.size();
    overlapCount = 0;
    req_n     = nPacked;
    req_valid = valid;
    modelK    = 1;
    guard = 0;
    while (rspCount - startRsp < nRsp && guard < 100) begin
      stepCycle();
      guard++;
    end
    req_valid = 4'b0;
    checkOutput({tag, ".responses"}, rspCount - startRsp, nRsp);
    checkOutput({tag, ".overlap"}, overlapCount, 0);
    for (int i = 0; i < nRsp; i++) begin
      if (startLog + i < grantLog.size())
        checkOutput($sformatf("%s.grant%0d", tag, i), grantLog[startLog + i], expOrder[i]);
      else
        checkOutput($sformatf("%s.grant%0d", tag, i), 0, expOrder[i]);
      if (startRsp + i < rspLog.size())
        checkOutput($sformatf("%s.rsp%0d", tag, i), rspLog[startRsp + i], expOrder[i]);
      else
        checkOutput($sformatf("%s.rsp%0d", tag, i), 0, expOrder[i]);
    end
  endtask

  initial begin
    logic [3:0] order[5];
    vec_t v;
    int savedRsp;

    vecs[0] = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd10}, 9, 4'b0001, 5'd10, 16'd55,    1'b0, 10};
    vecs[1] = '{4'b1111, {5'd4,  5'd3,  5'd2,  5'd1},  1, 4'b0010, 5'd2,  16'd1,     1'b0, 2};
    vecs[2] = '{4'b1001, {5'd20, 5'd0,  5'd0,  5'd5},  3, 4'b1000, 5'd20, 16'd6765,  1'b0, 4};
    vecs[3] = '{4'b1001, {5'd20, 5'd0,  5'd0,  5'd5},  2, 4'b0001, 5'd5,  16'd5,     1'b0, 3};
    vecs[4] = '{4'b0001, {5'd0,  5'd0,  5'd0,  5'd0},  1, 4'b0001, 5'd0,  16'd0,     1'b0, 2};
    vecs[5] = '{4'b0100, {5'd0,  5'd31, 5'd0,  5'd0},  4, 4'b0100, 5'd31, 16'd35549, 1'b0, 5};
    vecs[6] = '{4'b0011, {5'd0,  5'd0,  5'd23, 5'd24}, 5, 4'b0001, 5'd24, 16'd46368, 1'b0, 6};
    vecs[7] = '{4'b1010, {5'd7,  5'd0,  5'd12, 5'd0},  2, 4'b0010, 5'd12, 16'd144,   1'b0, 3};

    reset       = 1'b1;
    req_valid   = 4'b1111;
    req_n       = '0;
    calc_done   = 1'b0;
    calc_result = '0;
    doReset(2);
    reset = 1'b1;
    checkOutput("reset.req_ready", req_ready, 0);
    checkOutput("reset.rsp_valid", rsp_valid, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.calc_begin", calc_begin, 0);
    checkOutput("reset.calc_n", calc_n, 0);
    checkOutput("reset.rsp_data", rsp_data, 0);
    checkOutput("reset.rsp_err", rsp_err, 0);
    reset     = 1'b0;
    req_valid = 4'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Two requesters held: alternate 0, 2, 0.
    doReset(2);
    order = '{4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
    runHeld(4'b0101, {5'd0, 5'd6, 5'd0, 5'd3}, 3, order, "pair");

    // All requesters held: full rotation back to 0.
    doReset(2);
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    runHeld(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 5, order, "all");

    // Reset in the middle of WAIT for requester 2 aborts silently.
    doReset(2);
    req_n     = {5'd0, 5'd15, 5'd0, 5'd0};
    req_valid = 4'b0100;
    modelK    = 50;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      req_valid = 4'b0;
    end
    checkOutput("abort.busyInWait", busy, 1);
    savedRsp = rspCount;
    doReset(2);
    reset = 1'b1;
    checkOutput("abort.req_ready", req_ready, 0);
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.calc_n", calc_n, 0);
    checkOutput("abort.rsp_data", rsp_data, 0);
    checkOutput("abort.rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    stepCycle();
    checkOutput("abort.noResponse", rspCount, savedRsp);
    v = '{4'b0101, {5'd0, 5'd9, 5'd0, 5'd8}, 3, 4'b0001, 5'd8, 16'd21, 1'b0, 4};
    applyStimulus(v, "afterAbort");

    // Stray calc_done in IDLE and in ISSUE must be ignored.
    doReset(2);
    modelK    = 0;
    savedRsp  = rspCount;
    forceDone = 1'b1;
    stepCycle();
    forceDone = 1'b0;
    stepCycle();
    checkOutput("strayIdle.busy", busy, 0);
    checkOutput("strayIdle.noResponse", rspCount, savedRsp);
    req_n     = {5'd0, 5'd0, 5'd0, 5'd7};
    req_valid = 4'b0001;
    stepCycle();
    req_valid = 4'b0;
    forceDone = 1'b1;
    stepCycle();
    forceDone = 1'b0;
    checkOutput("strayIssue.beganHere", beginCycle, cycleNo);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("strayIssue.stillBusy", busy, 1);
    checkOutput("strayIssue.noResponse", rspCount, savedRsp);
    forceDone = 1'b1;
    stepCycle();
    forceDone = 1'b0;
    stepCycle();
    checkOutput("strayIssue.responses", rspCount, savedRsp + 1);
    checkOutput("strayIssue.rsp_valid", rspVec, 4'b0001);
    checkOutput("strayIssue.rsp_data", rspData, 16'd13);

`ifdef FIBO_ARB_TIMEOUT_EN
    v = '{4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 0, 4'b0010, 5'd9, 16'd0, 1'b1, 65};
    applyStimulus(v, "timeout");
    v = '{4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 64, 4'b0010, 5'd9, 16'd34, 1'b0, 65};
    applyStimulus(v, "doneAtLimit");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule
